tone_synth: RTL

Downstream audio stage: converts the 8-bit key code on `PBKey` (live or played back) into a square-wave speaker signal. The lowest set key bit selects one of eight notes, C4..C5; a 2-bit octave control rescales the note. A short silent articulation gap is inserted whenever the sounding note changes. The block runs on `RPUClk` (25 MHz) and drives the board speaker pin directly.

---
 rtl/tone_synth.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/tone_synth.sv
// Square-wave tone generator: lowest set bit of the registered key code picks a
// note C4..C5, Octave rescales its half-period, and a silent gap separates notes.
module tone_synth #(
  parameter int unsigned GAP_CYCLES = 250000
) (
  input  logic       RPUClk,
  input  logic       rst,
  input  logic [7:0] PBKey,
  input  logic       PlayEn,
  input  logic [1:0] Octave,
  output logic       Spk,
  output logic       NoteActive,
  output logic [2:0] NoteIdx
);

  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  localparam logic [1:0] SILENT = 2'd0;
  localparam logic [1:0] TONE   = 2'd1;
  localparam logic [1:0] GAP    = 2'd2;

  logic [7:0]    key_q;
  logic          en_q;
  logic [1:0]    oct_q;
  logic [1:0]    state_q, state_d;
  logic          spk_q, spk_d;
  logic [16:0]   cnt_q, cnt_d;
  logic [GW-1:0] g_q, g_d;
  logic [2:0]    lat_idx_q, lat_idx_d;
  logic [1:0]    lat_oct_q, lat_oct_d;
  logic [16:0]   half_lat_q, half_lat_d;

  logic          valid;
  logic [2:0]    idx;
  logic [16:0]   base;
  logic [16:0]   half_new;
  logic          note_changed;

  always_comb begin
    valid = |key_q;
    casez (key_q)
      8'b???????1: idx = 3'd0;
      8'b??????10: idx = 3'd1;
      8'b?????100: idx = 3'd2;
      8'b????1000: idx = 3'd3;
      8'b???10000: idx = 3'd4;
      8'b??100000: idx = 3'd5;
      8'b?1000000: idx = 3'd6;
      8'b10000000: idx = 3'd7;
      default:     idx = 3'd0;
    endcase

    case (idx)
      3'd0:    base = 17'd47778;
      3'd1:    base = 17'd42566;
      3'd2:    base = 17'd37921;
      3'd3:    base = 17'd35793;
      3'd4:    base = 17'd31888;
      3'd5:    base = 17'd28409;
      3'd6:    base = 17'd25310;
      default: base = 17'd23889;
    endcase

    // Largest base << 1 is 95556, which still fits in 17 bits.
    case (oct_q)
      2'd1:    half_new = base >> 1;
      2'd2:    half_new = base >> 2;
      2'd3:    half_new = base << 1;
      default: half_new = base;
    endcase

    note_changed = (idx != lat_idx_q) || (oct_q != lat_oct_q);
  end

  always_comb begin
    state_d    = state_q;
    spk_d      = spk_q;
    cnt_d      = cnt_q;
    g_d        = g_q;
    lat_idx_d  = lat_idx_q;
    lat_oct_d  = lat_oct_q;
    half_lat_d = half_lat_q;

    case (state_q)
      SILENT: begin
        spk_d = 1'b0;
        cnt_d = '0;
        if (en_q && valid) begin
          lat_idx_d  = idx;
          lat_oct_d  = oct_q;
          half_lat_d = half_new;
          spk_d      = 1'b1;
          state_d    = TONE;
        end
      end
      TONE: begin
        // Exits take priority over the half-period toggle.
        if (!en_q || !valid) begin
          state_d = SILENT;
          spk_d   = 1'b0;
          cnt_d   = '0;
        end else if (note_changed) begin
          state_d = GAP;
          spk_d   = 1'b0;
          cnt_d   = '0;
          g_d     = '0;
        end else if (cnt_q == half_lat_q - 17'd1) begin
          spk_d = ~spk_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 17'd1;
        end
      end
      GAP: begin
        spk_d = 1'b0;
        if (!en_q || !valid) begin
          state_d = SILENT;
        end else if (g_q == GAP_LAST) begin
          lat_idx_d  = idx;
          lat_oct_d  = oct_q;
          half_lat_d = half_new;
          spk_d      = 1'b1;
          cnt_d      = '0;
          state_d    = TONE;
        end else begin
          g_d = g_q + 1'b1;
        end
      end
      default: begin
        state_d = SILENT;
        spk_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge RPUClk) begin
    if (rst) begin
      key_q      <= '0;
      en_q       <= 1'b0;
      oct_q      <= '0;
      state_q    <= SILENT;
      spk_q      <= 1'b0;
      cnt_q      <= '0;
      g_q        <= '0;
      lat_idx_q  <= '0;
      lat_oct_q  <= '0;
      half_lat_q <= '0;
    end else begin
      key_q      <= PBKey;
      en_q       <= PlayEn;
      oct_q      <= Octave;
      state_q    <= state_d;
      spk_q      <= spk_d;
      cnt_q      <= cnt_d;
      g_q        <= g_d;
      lat_idx_q  <= lat_idx_d;
      lat_oct_q  <= lat_oct_d;
      half_lat_q <= half_lat_d;
    end
  end

  assign Spk        = spk_q;
  assign NoteActive = (state_q == TONE);
  assign NoteIdx    = lat_idx_q;

endmodule
